uart_igbt_frame_tx: RTL and testbench

//  Builds and transmits the IGBT control/status frame over RS-232; the transmit-side twin of the IGBT frame receiver.

---
 rtl/uart_igbt_frame_tx_pkg.sv | 60 ++++++
 rtl/uart_igbt_chk16.sv | 24 ++
 rtl/uart_igbt_frame_tx.sv | 158 +++++++++++++++
 tb/tb_uart_igbt_frame_tx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_igbt_frame_tx_pkg.sv
// uart_igbt_frame_tx_pkg.sv - IGBT frame constants shared by the transmitter and receiver.
// Header bytes, LEN values for both builds, byte indices, frame lengths, FSM states.
package uart_igbt_frame_tx_pkg;

   localparam logic [7:0] HEAD0_DEF = 8'hAF;
   localparam logic [7:0] HEAD1_DEF = 8'hFA;

   localparam logic [7:0] LEN_CHK   = 8'd9;
   localparam logic [7:0] LEN_NOCHK = 8'd7;

   localparam logic [3:0] IDX_HEAD0 = 4'd0;
   localparam logic [3:0] IDX_HEAD1 = 4'd1;
   localparam logic [3:0] IDX_LEN   = 4'd2;
   localparam logic [3:0] IDX_WORK  = 4'd3;
   localparam logic [3:0] IDX_CH_H  = 4'd4;
   localparam logic [3:0] IDX_CH_M  = 4'd5;
   localparam logic [3:0] IDX_CH_L  = 4'd6;
   localparam logic [3:0] IDX_DIS_H = 4'd7;
   localparam logic [3:0] IDX_DIS_M = 4'd8;
   localparam logic [3:0] IDX_DIS_L = 4'd9;
   localparam logic [3:0] IDX_CHK_H = 4'd10;
   localparam logic [3:0] IDX_CHK_L = 4'd11;

   localparam logic [3:0] FRAME_LEN_CHK   = 4'd12;
   localparam logic [3:0] FRAME_LEN_NOCHK = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_GAP,
      ST_DONE
   } tx_state_t;

   typedef struct packed {
      logic [7:0]  work;
      logic [23:0] charge;
      logic [23:0] discharge;
   } igbt_fields_t;

   // Sum of LEN..DIS_L, each byte zero-extended, wrapping at 16 bits.
   function automatic logic [15:0] chk16(
      input logic [7:0]   len,
      input igbt_fields_t f
   );
      logic [15:0] s;
      s = {8'h00, len};
      s = s + {8'h00, f.work};
      s = s + {8'h00, f.charge[23:16]};
      s = s + {8'h00, f.charge[15:8]};
      s = s + {8'h00, f.charge[7:0]};
      s = s + {8'h00, f.discharge[23:16]};
      s = s + {8'h00, f.discharge[15:8]};
      s = s + {8'h00, f.discharge[7:0]};
      return s;
   endfunction

endpackage

// File: rtl/uart_igbt_chk16.sv
// uart_igbt_chk16.sv - registered 16-bit checksum over the eight covered frame bytes.
// Only built when UART_IGBT_TX_CHKSUM_EN is defined.
`ifdef UART_IGBT_TX_CHKSUM_EN
module uart_igbt_chk16
   import uart_igbt_frame_tx_pkg::*;
(
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         load,
   input  logic [7:0]   len,
   input  igbt_fields_t fields,
   output logic [15:0]  sum
);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sum <= 16'h0000;
      end else if (load) begin
         sum <= chk16(len, fields);
      end
   end

endmodule
`endif

// File: rtl/uart_igbt_frame_tx.sv
// uart_igbt_frame_tx.sv - IGBT control/status frame transmitter feeding uart_send.
// Define UART_IGBT_TX_CHKSUM_EN to append CHK_H/CHK_L (12-byte frame, LEN=9).
module uart_igbt_frame_tx
   import uart_igbt_frame_tx_pkg::*;
#(
   parameter logic [7:0] HEAD0        = HEAD0_DEF,
   parameter logic [7:0] HEAD1        = HEAD1_DEF,
   parameter int          GAP_CYC      = 16,
   parameter int          BUSY_TIMEOUT = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        frame_req,
   input  logic [7:0]  work_in,
   input  logic [23:0] charge_in,
   input  logic [23:0] discharge_in,
   input  logic        tx_busy,
   output logic        send_en,
   output logic [7:0]  send_data,
   output logic        frame_busy,
   output logic        frame_done,
   output logic        frame_err
);

`ifdef UART_IGBT_TX_CHKSUM_EN
   localparam logic [7:0] LEN_VAL  = LEN_CHK;
   localparam logic [3:0] LAST_IDX = FRAME_LEN_CHK - 4'd1;
`else
   localparam logic [7:0] LEN_VAL  = LEN_NOCHK;
   localparam logic [3:0] LAST_IDX = FRAME_LEN_NOCHK - 4'd1;
`endif

   localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   tx_state_t    state;
   igbt_fields_t fields;
   logic [3:0]   idx;
   logic [15:0]  cnt;
   logic [7:0]   cur_byte;
   logic         step;

`ifdef UART_IGBT_TX_CHKSUM_EN
   logic [15:0] chk_sum;

   uart_igbt_chk16 u_chk16 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (state == ST_LOAD),
      .len       (LEN_VAL),
      .fields    (fields),
      .sum       (chk_sum)
   );
`endif

   always_comb begin
      cur_byte = 8'h00;
      unique case (idx)
         IDX_HEAD0: cur_byte = HEAD0;
         IDX_HEAD1: cur_byte = HEAD1;
         IDX_LEN:   cur_byte = LEN_VAL;
         IDX_WORK:  cur_byte = fields.work;
         IDX_CH_H:  cur_byte = fields.charge[23:16];
         IDX_CH_M:  cur_byte = fields.charge[15:8];
         IDX_CH_L:  cur_byte = fields.charge[7:0];
         IDX_DIS_H: cur_byte = fields.discharge[23:16];
         IDX_DIS_M: cur_byte = fields.discharge[15:8];
         IDX_DIS_L: cur_byte = fields.discharge[7:0];
`ifdef UART_IGBT_TX_CHKSUM_EN
         IDX_CHK_H: cur_byte = chk_sum[15:8];
         IDX_CHK_L: cur_byte = chk_sum[7:0];
`endif
         default:   cur_byte = 8'h00;
      endcase
   end

   // Byte finished: tx_busy fell and the inter-byte gap (if any) has elapsed.
   assign step = ((state == ST_WAIT_LO) && !tx_busy && (GAP_CYC == 0)) ||
                 ((state == ST_GAP) && (cnt == GAP_LAST));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         fields     <= '0;
         idx        <= 4'd0;
         cnt        <= 16'h0000;
         send_en    <= 1'b0;
         send_data  <= 8'h00;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         send_en    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (frame_req) begin
                  fields     <= '{work: work_in,
                                  charge: charge_in,
                                  discharge: discharge_in};
                  idx        <= 4'd0;
                  frame_busy <= 1'b1;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (!tx_busy) begin
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               send_data <= cur_byte;
               send_en   <= 1'b1;
               cnt       <= 16'h0000;
               state     <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (tx_busy) begin
                  state <= ST_WAIT_LO;
               end else if (cnt == TO_LAST) begin
                  frame_err  <= 1'b1;
                  frame_busy <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  cnt   <= 16'h0000;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               cnt <= cnt + 16'd1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
         if (step) begin
            if (idx == LAST_IDX) begin
               frame_done <= 1'b1;
               frame_busy <= 1'b0;
               state      <= ST_DONE;
            end else begin
               idx   <= idx + 4'd1;
               state <= ST_SEND;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_igbt_frame_tx.sv
// tb_uart_igbt_frame_tx.sv - directed plus randomized bench for uart_igbt_frame_tx.
// Follows UART_IGBT_TX_CHKSUM_EN to choose the expected frame layout.
module tb_uart_igbt_frame_tx;

   typedef logic [7:0] bq_t [$];

`ifdef UART_IGBT_TX_CHKSUM_EN
   localparam logic [7:0] LEN = 8'd9;
`else
   localparam logic [7:0] LEN = 8'd7;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        frame_req = 1'b0;
   logic [7:0]  work_in = 8'h00;
   logic [23:0] charge_in = 24'h0;
   logic [23:0] discharge_in = 24'h0;
   logic        tx_busy;
   logic        send_en;
   logic [7:0]  send_data;
   logic        frame_busy;
   logic        frame_done;
   logic        frame_err;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   en_cyc = -1;
   int   err_cyc = -1;
   logic busy_at_done = 1'b1;
   logic busy_at_err = 1'b1;
   bit   uart_alive = 1'b1;
   bq_t  cap_q;
   int   m_dly = 0;
   int   m_hold = 0;

   always #5 sys_clk = ~sys_clk;

   uart_igbt_frame_tx #(
      .HEAD0        (8'hAF),
      .HEAD1        (8'hFA),
      .GAP_CYC      (16),
      .BUSY_TIMEOUT (64)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .frame_req    (frame_req),
      .work_in      (work_in),
      .charge_in    (charge_in),
      .discharge_in (discharge_in),
      .tx_busy      (tx_busy),
      .send_en      (send_en),
      .send_data    (send_data),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .frame_err    (frame_err)
   );

   always @(posedge sys_clk) cyc <= cyc + 1;

   // uart_send model: busy rises 3 clocks after send_en, stays high 20 clocks
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_busy <= 1'b0;
         m_dly   <= 0;
         m_hold  <= 0;
      end else begin
         if (m_dly > 0) begin
            m_dly <= m_dly - 1;
            if (m_dly == 1) begin
               tx_busy <= 1'b1;
               m_hold  <= 20;
            end
         end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) tx_busy <= 1'b0;
         end
         if (send_en && uart_alive) m_dly <= 2;
      end
   end

   always @(negedge sys_clk) begin
      if (send_en) begin
         cap_q.push_back(send_data);
         if (en_cyc < 0) en_cyc = cyc;
      end
      if (frame_done) begin
         done_cnt++;
         busy_at_done = frame_busy;
      end
      if (frame_err) begin
         err_cnt++;
         err_cyc = cyc;
         busy_at_err = frame_busy;
      end
   end

   function automatic bq_t ref_frame(input logic [7:0] w,
                                     input logic [23:0] c,
                                     input logic [23:0] d);
      bq_t q;
      logic [7:0] body [7];
      int sum;
      body = '{w, c[23:16], c[15:8], c[7:0], d[23:16], d[15:8], d[7:0]};
      q = '{8'hAF, 8'hFA, LEN};
      sum = int'(LEN);
      foreach (body[i]) begin
         q.push_back(body[i]);
         sum += int'(body[i]);
      end
`ifdef UART_IGBT_TX_CHKSUM_EN
      begin
         logic [15:0] s16;
         s16 = 16'(sum % 65536);
         q.push_back(s16[15:8]);
         q.push_back(s16[7:0]);
      end
`endif
      return q;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      work_in      = 8'($urandom);
      charge_in    = 24'($urandom);
      discharge_in = 24'($urandom);
   endtask

   task automatic pulse(input logic [7:0] w, input logic [23:0] c,
                        input logic [23:0] d);
      @(negedge sys_clk);
      work_in      = w;
      charge_in    = c;
      discharge_in = d;
      frame_req    = 1'b1;
      @(negedge sys_clk);
      frame_req = 1'b0;
      scramble();
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
   endtask

   task automatic cmp_frame(input string tag, input bq_t exp);
      check({tag, "_nbytes"}, cap_q.size(), exp.size());
      foreach (exp[i])
         if (i < cap_q.size())
            check($sformatf("%s_b%0d", tag, i), cap_q[i], exp[i]);
      check({tag, "_ndone"}, done_cnt, 32'd1);
      check({tag, "_busy_at_done"}, busy_at_done, 32'd0);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] w,
                            input logic [23:0] c, input logic [23:0] d);
      bq_t exp;
      exp = ref_frame(w, c, d);
      cap_q.delete();
      done_cnt = 0;
      pulse(w, c, d);
      wait_done(tag);
      repeat (2) @(negedge sys_clk);
      cmp_frame(tag, exp);
   endtask

   initial begin
      bq_t exp;
      int n;

      repeat (3) @(negedge sys_clk);
      check("rst_send_en", send_en, 0);
      check("rst_send_data", send_data, 8'h00);
      check("rst_frame_busy", frame_busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // reference frame with latency checks
      exp = ref_frame(8'h01, 24'h0186A0, 24'h000064);
      cap_q.delete();
      done_cnt = 0;
      @(negedge sys_clk);
      work_in      = 8'h01;
      charge_in    = 24'h0186A0;
      discharge_in = 24'h000064;
      frame_req    = 1'b1;
      @(negedge sys_clk);
      frame_req = 1'b0;
      scramble();
      check("lat_busy_next", frame_busy, 1);
      check("lat_en_c1", send_en, 0);
      @(negedge sys_clk);
      check("lat_en_c2", send_en, 0);
      @(negedge sys_clk);
      check("lat_en_c3", send_en, 1);
      check("lat_first_byte", send_data, 8'hAF);
      wait_done("ref");
      repeat (2) @(negedge sys_clk);
      cmp_frame("ref", exp);

      // requests during the frame and in the DONE cycle are dropped
      exp = ref_frame(8'h11, 24'h223344, 24'h556677);
      cap_q.delete();
      done_cnt = 0;
      pulse(8'h11, 24'h223344, 24'h556677);
      n = 0;
      while (cap_q.size() < 5 && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check("ign_reach_b5", 32'(cap_q.size() >= 5), 1);
      pulse(8'hEE, 24'hDDCCBB, 24'hAA9988);
      n = 0;
      while (!frame_done && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check("ign_done_seen", frame_done, 1);
      work_in      = 8'h5A;
      charge_in    = 24'hC0FFEE;
      discharge_in = 24'h123456;
      frame_req    = 1'b1;
      @(negedge sys_clk);
      check("ign_done_cycle", frame_busy, 0);
      @(negedge sys_clk);
      check("ign_next_accept", frame_busy, 1);
      frame_req = 1'b0;
      scramble();
      cmp_frame("ign_first", exp);
      exp = ref_frame(8'h5A, 24'hC0FFEE, 24'h123456);
      cap_q.delete();
      done_cnt = 0;
      wait_done("ign_second");
      repeat (2) @(negedge sys_clk);
      cmp_frame("ign_second", exp);
      repeat (100) @(negedge sys_clk);
      check("ign_no_extra", done_cnt, 1);

      // all-ones fields then random fields
      for (int k = 0; k < 4; k++) begin
         if (k == 0)
            run_frame("ones", 8'hFF, 24'hFFFFFF, 24'hFFFFFF);
         else
            run_frame($sformatf("rnd%0d", k), 8'($urandom),
                      24'($urandom), 24'($urandom));
      end

      // uart never goes busy: abort after the timeout
      uart_alive = 1'b0;
      cap_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      en_cyc   = -1;
      err_cyc  = -1;
      pulse(8'h01, 24'h0186A0, 24'h000064);
      n = 0;
      while (err_cnt == 0 && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      repeat (3) @(negedge sys_clk);
      check("to_err_count", err_cnt, 1);
      check("to_err_delay", err_cyc - en_cyc, 64);
      check("to_busy_at_err", busy_at_err, 0);
      check("to_nbytes", cap_q.size(), 1);
      if (cap_q.size() > 0) check("to_byte0", cap_q[0], 8'hAF);
      check("to_no_done", done_cnt, 0);
      uart_alive = 1'b1;
      repeat (5) @(negedge sys_clk);

      // reset while waiting for tx_busy to fall on byte 3
      cap_q.delete();
      done_cnt = 0;
      pulse(8'($urandom), 24'($urandom), 24'($urandom));
      n = 0;
      while (!(cap_q.size() == 3 && tx_busy) && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check("mrst_reach_b3", 32'(cap_q.size() == 3 && tx_busy), 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("mrst_send_en", send_en, 0);
      check("mrst_send_data", send_data, 8'h00);
      check("mrst_frame_busy", frame_busy, 0);
      check("mrst_frame_done", frame_done, 0);
      check("mrst_frame_err", frame_err, 0);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      run_frame("after_rst", 8'($urandom), 24'($urandom), 24'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
